fsm_input_conditioner: RTL and testbench

- Input front end for the behavioural FSM: takes three raw, asynchronous, possibly bouncing control lines and delivers clean, clock-synchronous levels on x1, x2, x3.
- Per channel: 2-flop synchronizer, then a debounce state machine with counter.
- Also produces rise pulses and a combined change strobe for the downstream FSM.

---
 rtl/fsm_input_conditioner.sv | 91 +++++++++
 tb/tb_fsm_input_conditioner.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fsm_input_conditioner.sv
// Conditions three raw, asynchronous control lines into clean synchronous levels
// (2-flop synchronizer plus per-channel debounce FSM) with rise and change strobes.
module fsm_input_conditioner #(
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter int         CNT_W           = 4,
  parameter logic [2:0] RESET_VAL       = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] raw_in,
  input  logic       enable,
  output logic       x1,
  output logic       x2,
  output logic       x3,
  output logic [2:0] x_rise,
  output logic       x_changed
);

  typedef enum logic {STABLE, PEND} chan_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       s1;
  logic [2:0]       s2;
  logic [2:0]       stab;
  logic [2:0]       stab_n;
  logic [2:0]       rise_n;
  logic             changed_n;
  chan_state_t      state   [3];
  chan_state_t      state_n [3];
  logic [CNT_W-1:0] cnt     [3];
  logic [CNT_W-1:0] cnt_n   [3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1        <= RESET_VAL;
      s2        <= RESET_VAL;
      stab      <= RESET_VAL;
      x_rise    <= 3'b000;
      x_changed <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        state[i] <= STABLE;
        cnt[i]   <= '0;
      end
    end else begin
      s1        <= raw_in;
      s2        <= s1;
      stab      <= stab_n;
      x_rise    <= rise_n;
      x_changed <= changed_n;
      for (int i = 0; i < 3; i++) begin
        state[i] <= state_n[i];
        cnt[i]   <= cnt_n[i];
      end
    end
  end

  // A new level is accepted only after it has been seen on DEBOUNCE_CYCLES
  // consecutive enabled samples; any return to the accepted level restarts.
  always_comb begin
    stab_n = stab;
    for (int i = 0; i < 3; i++) begin
      state_n[i] = state[i];
      cnt_n[i]   = cnt[i];
      if (!enable || (s2[i] == stab[i])) begin
        state_n[i] = STABLE;
        cnt_n[i]   = '0;
      end else if (state[i] == STABLE) begin
        state_n[i] = PEND;
        cnt_n[i]   = CNT_ONE;
      end else if (cnt[i] == CNT_LAST) begin
        state_n[i] = STABLE;
        cnt_n[i]   = '0;
        stab_n[i]  = s2[i];
      end else begin
        cnt_n[i]   = cnt[i] + CNT_ONE;
      end
    end
  end

  always_comb begin
    rise_n    = stab_n & ~stab;
    changed_n = |(stab_n ^ stab);
  end

  assign x1 = stab[2];
  assign x2 = stab[1];
  assign x3 = stab[0];

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Self-checking bench for fsm_input_conditioner: directed scenarios with literal
// expectations, then randomized stimulus compared against a behavioural model.
module tb_fsm_input_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] raw_in = 3'b000;
  logic       enable = 1'b1;
  logic       x1, x2, x3;
  logic [2:0] x_rise;
  logic       x_changed;

  int errors = 0;
  int checks = 0;

  fsm_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(4),
    .RESET_VAL(3'b000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .raw_in(raw_in),
    .enable(enable),
    .x1(x1),
    .x2(x2),
    .x3(x3),
    .x_rise(x_rise),
    .x_changed(x_changed)
  );

  always #5 clk = ~clk;

  // Reference: two-sample delay line, then a level is accepted once it has
  // differed from the current one on D consecutive enabled samples.
  logic [2:0] m1, m2, mx, mrise, mnext;
  logic       mchg;
  int         run [3];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m1 = 3'b000; m2 = 3'b000; mx = 3'b000; mrise = 3'b000; mchg = 1'b0;
      for (int i = 0; i < 3; i++) run[i] = 0;
    end else begin
      mnext = mx;
      for (int i = 0; i < 3; i++) begin
        if (enable && (m2[i] != mx[i])) begin
          run[i] = run[i] + 1;
          if (run[i] == D) begin
            mnext[i] = m2[i];
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      mrise = mnext & ~mx;
      mchg  = (mnext != mx);
      mx    = mnext;
      m2    = m1;
      m1    = raw_in;
    end
  end

  task automatic checkOutput(input string name, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("model x", {x1, x2, x3}, mx);
      checkOutput("model x_rise", x_rise, mrise);
      checkOutput("model x_changed", {2'b00, x_changed}, {2'b00, mchg});
    end
  end

  task automatic applyStimulus(input logic [2:0] raw, input logic en);
    raw_in = raw;
    enable = en;
  endtask

  task automatic expectLevel(input string name, input logic [2:0] ex, input logic [2:0] er, input logic ec);
    @(negedge clk);
    checkOutput({name, " x"}, {x1, x2, x3}, ex);
    checkOutput({name, " x_rise"}, x_rise, er);
    checkOutput({name, " x_changed"}, {2'b00, x_changed}, {2'b00, ec});
  endtask

  task automatic holdAndCheck(input string name, input logic [2:0] raw, input logic [2:0] oldX,
                              input logic [2:0] newX, input logic [2:0] newRise);
    applyStimulus(raw, 1'b1);
    repeat (D + 1) expectLevel(name, oldX, 3'b000, 1'b0);
    expectLevel(name, newX, newRise, 1'b1);
    expectLevel(name, newX, 3'b000, 1'b0);
  endtask

  initial begin
    applyStimulus(3'b111, 1'b1);
    #1 reset = 1'b1;
    #1 checkOutput("reset held x", {x1, x2, x3}, 3'b000);
    checkOutput("reset held x_rise", x_rise, 3'b000);
    #1 reset = 1'b0;

    repeat (D + 1) expectLevel("reset_release", 3'b000, 3'b000, 1'b0);
    expectLevel("reset_release", 3'b111, 3'b111, 1'b1);
    expectLevel("reset_release", 3'b111, 3'b000, 1'b0);

    holdAndCheck("fall_all", 3'b000, 3'b111, 3'b000, 3'b000);
    holdAndCheck("clean_step", 3'b010, 3'b000, 3'b010, 3'b010);

    applyStimulus(3'b011, 1'b1);
    repeat (2) expectLevel("glitch", 3'b010, 3'b000, 1'b0);
    applyStimulus(3'b010, 1'b1);
    repeat (8) expectLevel("glitch", 3'b010, 3'b000, 1'b0);

    holdAndCheck("back_to_zero", 3'b000, 3'b010, 3'b000, 3'b000);
    holdAndCheck("simultaneous", 3'b011, 3'b000, 3'b011, 3'b011);
    holdAndCheck("falling", 3'b001, 3'b011, 3'b001, 3'b000);

    for (int k = 0; k < 4; k++) begin
      applyStimulus(k[0] ? 3'b001 : 3'b101, 1'b1);
      expectLevel("bounce", 3'b001, 3'b000, 1'b0);
    end
    holdAndCheck("bounce_settle", 3'b101, 3'b001, 3'b101, 3'b100);

    applyStimulus(3'b100, 1'b1);
    repeat (3) expectLevel("enable_pend", 3'b101, 3'b000, 1'b0);
    applyStimulus(3'b100, 1'b0);
    repeat (3) expectLevel("enable_low", 3'b101, 3'b000, 1'b0);
    applyStimulus(3'b100, 1'b1);
    repeat (D - 1) expectLevel("enable_restart", 3'b101, 3'b000, 1'b0);
    expectLevel("enable_restart", 3'b100, 3'b000, 1'b1);
    expectLevel("enable_restart", 3'b100, 3'b000, 1'b0);

    applyStimulus(3'b111, 1'b1);
    repeat (3) expectLevel("reset_mid_pend", 3'b100, 3'b000, 1'b0);
    #2 reset = 1'b1;
    applyStimulus(3'b000, 1'b1);
    #1 checkOutput("reset_mid x", {x1, x2, x3}, 3'b000);
    #1 reset = 1'b0;
    repeat (8) expectLevel("after_reset_mid", 3'b000, 3'b000, 1'b0);

    for (int k = 0; k < 150; k++) begin
      applyStimulus(3'($urandom_range(0, 7)), ($urandom_range(0, 9) != 0));
      repeat ($urandom_range(1, 7)) @(negedge clk);
      if ($urandom_range(0, 29) == 0) begin
        #2 reset = 1'b1;
        #2 reset = 1'b0;
      end
    end
    applyStimulus(raw_in, 1'b1);
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
